ps2_keyboard_rx: RTL
====================

Name: ps2_keyboard_rx

Overview:
- Receives PS/2 keyboard frames and decodes scan-code set 2 make, break and extended sequences.
- Presents a 32-bit status word that drives the Frogger system's keyboard_data input, which the processor polls.
- Sits directly upstream of the system top, between the board PS/2 pins and keyboard_data.
- Single clock domain (system clk); the PS/2 pins are asynchronous and are synchronised inside the block.

Parameters:
- bus, 32, width of keyboard_data; must be >= 32.
- TIMEOUT_CYCLES, 100000, clk cycles allowed between PS/2 falling edges inside a frame (2 ms at 50 MHz).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- ps2_clk  input  1  raw PS/2 clock from the keyboard; asynchronous.
- ps2_data  input  1  raw PS/2 data from the keyboard; asynchronous.
- keyboard_data  output  bus  status word, layout given under Behaviour.
- event_valid  output  1  one-cycle pulse when keyboard_data is updated by a make or break event.

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high, named reset.
- Reset values: keyboard_data = 0, event_valid = 0, FSM = IDLE, bit counter = 0, timeout counter = 0, ext_pend = 0, brk_pend = 0.
- Reset mid-frame discards the partial frame. The synchroniser flops reset to 1 (idle bus).
- Input synchronisation: ps2_clk and ps2_data each pass through a 2-flop synchroniser. A third flop on the clock path provides edge detection.
- Falling edge (fall) = previous synchronised clk is 1 and current is 0. Data is sampled from synchronised ps2_data in the same cycle as fall.
- Frame format: 11 bits, LSB-first data. Order is start(0), d0..d7, odd parity, stop(1).
- IDLE state:
  - fall with data = 0 -> RECV, bitcnt = 0.
  - fall with data = 1 -> ignored, stay IDLE.
- RECV state:
  - Each fall shifts the sampled bit into a 10-bit shift register and increments bitcnt.
  - On the 10th fall (the stop bit), go to CHECK.
  - The timeout counter clears on every fall and increments otherwise.
  - If the counter reaches TIMEOUT_CYCLES-1: go to IDLE, discard the frame, set err.
- CHECK state (1 cycle):
  - Valid when stop = 1 and XOR(d0..d7, parity) = 1. Valid -> DECODE.
  - Invalid -> set err, go to IDLE, no event.
- DECODE state (1 cycle), then IDLE:
  - byte 0xE0: ext_pend <= 1. No event.
  - byte 0xF0: brk_pend <= 1. No event.
  - Any other byte with brk_pend = 1 (break):
    - If byte == code and ext_pend == ext, then held <= 0. Otherwise held is unchanged.
    - code and ext are unchanged.
    - evcnt increments and event_valid pulses.
  - Any other byte with brk_pend = 0 (make):
    - code <= byte, ext <= ext_pend, held <= 1.
    - evcnt increments and event_valid pulses. Typematic repeats count as events.
  - ext_pend and brk_pend clear after any non-prefix byte.
- keyboard_data layout:
  - [7:0] code.
  - [8] ext.
  - [9] held.
  - [15:10] 0.
  - [23:16] evcnt, 8-bit, wraps 255 -> 0.
  - [30:24] 0.
  - [31] err, sticky; cleared only by reset.
  - Bits above 31 (bus > 32) are 0.
- Latency: if the stop-bit fall is detected in cycle T, CHECK is at T+1 and DECODE at T+2. Updated keyboard_data and event_valid = 1 are visible at T+3.
- event_valid is high for exactly 1 cycle per event.
- A fall during CHECK or DECODE is ignored. The PS/2 bit period is ≥ 3000 cycles, so this cannot occur legally.
- Error frames and timeouts never change [30:0].

Test Plan:
- Reset, then send a valid frame for 0x1D -> event_valid pulses once at T+3; keyboard_data = 0x0001021D.
- Then send 0xF0 followed by 0x1D -> exactly one event_valid; keyboard_data = 0x0002001D.
- Send 0xE0 followed by 0x75 (up arrow) -> keyboard_data = 0x00030375. A following break 0xF0 0x75 (no E0) leaves held = 1, with keyboard_data = 0x00040375.
- Send the frame for 0x1D with wrong parity -> no event_valid; bit 31 set; [30:0] unchanged. A following valid frame decodes normally with bit 31 still 1.
- Run with TIMEOUT_CYCLES = 1000:
  - Send start plus 4 bits, then idle -> FSM in IDLE within 1000 cycles and bit 31 set.
  - A following full frame for 0x29 -> code = 0x29, held = 1.
- Assert reset mid-frame (after 6 bits) -> keyboard_data = 0 and event_valid = 0 on the next cycle. The rest of the interrupted frame produces no event; the next complete frame decodes correctly.
- Send 256 make frames -> evcnt wraps to 0x00 and event_valid count = 256.

Source files
------------

// File: rtl/ps2_keyboard_rx_if.sv
// ps2_keyboard_rx_if: PS/2 pin pair in, keyboard status word and event pulse out
interface ps2_keyboard_rx_if #(parameter int bus = 32);
   logic           ps2_clk;
   logic           ps2_data;
   logic [bus-1:0] keyboard_data;
   logic           event_valid;
   modport master (output ps2_clk, output ps2_data, input keyboard_data, input event_valid);
   modport slave (input ps2_clk, input ps2_data, output keyboard_data, output event_valid);
endinterface

// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx: PS/2 frame receiver with scan-code set 2 make/break/extended decode
module ps2_keyboard_rx #(
   parameter int bus = 32,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input logic clk,
   input logic reset,
   ps2_keyboard_rx_if.slave kb
);
   typedef enum logic [1:0] {IDLE, RECV, CHECK, DECODE} state_t;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
   state_t state_q, state_d;
   logic [2:0] clk_sync_q;
   logic [1:0] dat_sync_q;
   logic [3:0] bitcnt_q, bitcnt_d;
   logic [9:0] sr_q, sr_d;
   logic [TW-1:0] to_q, to_d;
   logic [7:0] code_q, code_d, evcnt_q, evcnt_d;
   logic ext_q, ext_d, held_q, held_d, err_q, err_d;
   logic ext_pend_q, ext_pend_d, brk_pend_q, brk_pend_d, ev_q, ev_d;
   logic fall, bit_in;
   logic [31:0] word;
   assign fall = clk_sync_q[2] & ~clk_sync_q[1];
   assign bit_in = dat_sync_q[1];
   assign word = {err_q, 7'd0, evcnt_q, 6'd0, held_q, ext_q, code_q};
   assign kb.keyboard_data = bus'(word);
   assign kb.event_valid = ev_q;
   // synchronisers idle high; all decode state and the status word reset to zero
   always_ff @(posedge clk) begin
      if (reset) begin
         clk_sync_q <= '1;
         dat_sync_q <= '1;
         state_q    <= IDLE;
         bitcnt_q   <= '0;
         sr_q       <= '0;
         to_q       <= '0;
         code_q     <= '0;
         evcnt_q    <= '0;
         ext_q      <= 1'b0;
         held_q     <= 1'b0;
         err_q      <= 1'b0;
         ext_pend_q <= 1'b0;
         brk_pend_q <= 1'b0;
         ev_q       <= 1'b0;
      end else begin
         clk_sync_q <= {clk_sync_q[1:0], kb.ps2_clk};
         dat_sync_q <= {dat_sync_q[0], kb.ps2_data};
         state_q    <= state_d;
         bitcnt_q   <= bitcnt_d;
         sr_q       <= sr_d;
         to_q       <= to_d;
         code_q     <= code_d;
         evcnt_q    <= evcnt_d;
         ext_q      <= ext_d;
         held_q     <= held_d;
         err_q      <= err_d;
         ext_pend_q <= ext_pend_d;
         brk_pend_q <= brk_pend_d;
         ev_q       <= ev_d;
      end
   end
   // frame reception, validity check and scan-code decode
   always_comb begin
      state_d    = state_q;
      bitcnt_d   = bitcnt_q;
      sr_d       = sr_q;
      to_d       = to_q;
      code_d     = code_q;
      evcnt_d    = evcnt_q;
      ext_d      = ext_q;
      held_d     = held_q;
      err_d      = err_q;
      ext_pend_d = ext_pend_q;
      brk_pend_d = brk_pend_q;
      ev_d       = 1'b0;
      case (state_q)
         IDLE: begin
            to_d = '0;
            if (fall && !bit_in) begin
               state_d  = RECV;
               bitcnt_d = '0;
            end
         end
         RECV: begin
            if (fall) begin
               sr_d     = {bit_in, sr_q[9:1]};
               bitcnt_d = bitcnt_q + 4'd1;
               to_d     = '0;
               state_d  = (bitcnt_q == 4'd9) ? CHECK : RECV;
            end else if (to_q == TO_LAST) begin
               state_d = IDLE;
               err_d   = 1'b1;
            end else begin
               to_d = to_q + 1'b1;
            end
         end
         CHECK: begin
            state_d = (sr_q[9] && ^sr_q[8:0]) ? DECODE : IDLE;
            err_d   = err_q | ~(sr_q[9] & ^sr_q[8:0]);
         end
         DECODE: begin
            state_d = IDLE;
            if (sr_q[7:0] == 8'hE0) begin
               ext_pend_d = 1'b1;
            end else if (sr_q[7:0] == 8'hF0) begin
               brk_pend_d = 1'b1;
            end else begin
               ext_pend_d = 1'b0;
               brk_pend_d = 1'b0;
               evcnt_d    = evcnt_q + 8'd1;
               ev_d       = 1'b1;
               if (brk_pend_q) begin
                  held_d = (sr_q[7:0] == code_q && ext_pend_q == ext_q) ? 1'b0 : held_q;
               end else begin
                  code_d = sr_q[7:0];
                  ext_d  = ext_pend_q;
                  held_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end
endmodule
